// File: rtl/cpu_pkg.sv
// Shared types for the ID/EX stage register and its load-use hazard logic.
package cpu_pkg;

    localparam int unsigned ALUOP_W = 3;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef enum logic [0:0] {RUN, STALL} hz_state_t;

    typedef struct packed {
        logic               RegWrite;
        logic               MemRead;
        logic               MemWrite;
        logic               setFlag;
        logic [ALUOP_W-1:0] ALUOp;
        logic [4:0]         Rd;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '{
        RegWrite: 1'b0,
        MemRead:  1'b0,
        MemWrite: 1'b0,
        setFlag:  1'b0,
        ALUOp:    '0,
        Rd:       ZERO_REG
    };

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage register.
interface id_ex_stage_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
);
    logic              flush_ID;
    logic [4:0]        Rd_ID;
    logic [4:0]        Rn_ID;
    logic [4:0]        Rm_ID;
    logic              RegWrite_ID;
    logic              MemRead_ID;
    logic              MemWrite_ID;
    logic              setFlag_ID;
    logic              isMOV_ID;
    logic [2:0]        ALUOp_ID;
    logic [DATA_W-1:0] Da_ID;
    logic [DATA_W-1:0] Db_ID;
    logic [DATA_W-1:0] imm_ID;

    logic [4:0]        Rd_EX;
    logic              RegWrite_EX;
    logic              MemRead_EX;
    logic              MemWrite_EX;
    logic              setFlag_EX;
    logic [2:0]        ALUOp_EX;
    logic [DATA_W-1:0] Da_EX;
    logic [DATA_W-1:0] Db_EX;
    logic [DATA_W-1:0] imm_EX;
    logic              stall_ID;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush_ID, Rd_ID, Rn_ID, Rm_ID, RegWrite_ID, MemRead_ID, MemWrite_ID,
               setFlag_ID, isMOV_ID, ALUOp_ID, Da_ID, Db_ID, imm_ID,
        input  Rd_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, setFlag_EX, ALUOp_EX,
               Da_EX, Db_EX, imm_EX, stall_ID, bubble_cnt
    );

    modport slave (
        input  flush_ID, Rd_ID, Rn_ID, Rm_ID, RegWrite_ID, MemRead_ID, MemWrite_ID,
               setFlag_ID, isMOV_ID, ALUOp_ID, Da_ID, Db_ID, imm_ID,
        output Rd_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, setFlag_EX, ALUOp_EX,
               Da_EX, Db_EX, imm_EX, stall_ID, bubble_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: a load in EX whose Rd is read by the ID instruction.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       mem_read_ex,
    input  logic       reg_write_ex,
    input  logic [4:0] rd_ex,
    input  logic [4:0] rd_id,
    input  logic [4:0] rn_id,
    input  logic [4:0] rm_id,
    input  logic       is_mov_id,
    output logic       hazard
);

    // MOVK merges into the old Rd, so Rd counts as a source for MOV instructions.
    assign hazard = mem_read_ex & reg_write_ex & (rd_ex != ZERO_REG) &
                    ((rd_ex == rn_id) | (rd_ex == rm_id) | (is_mov_id & (rd_ex == rd_id)));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall FSM and saturating bubble counter.
module id_ex_stage_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input logic             clk,
    input logic             reset,
    id_ex_stage_reg_if.slave bus
);

    localparam logic [1:0] STALL_CYC = 2'(LOAD_LAT - 1);

    hz_state_t         state_q;
    logic [1:0]        cnt_q;
    id_ex_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] da_q, da_d;
    logic [DATA_W-1:0] db_q, db_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]  bub_q;
    logic              hazard;
    logic              stall;
    logic              load_bubble;

    load_use_detect u_detect (
        .mem_read_ex  (ctrl_q.MemRead),
        .reg_write_ex (ctrl_q.RegWrite),
        .rd_ex        (ctrl_q.Rd),
        .rd_id        (bus.Rd_ID),
        .rn_id        (bus.Rn_ID),
        .rm_id        (bus.Rm_ID),
        .is_mov_id    (bus.isMOV_ID),
        .hazard       (hazard)
    );

    // Flush wins over stall: the squashed instruction needs no operand, so no hold.
    always_comb begin
        stall       = 1'b0;
        load_bubble = 1'b0;
        if (bus.flush_ID) begin
            load_bubble = 1'b1;
        end else if (state_q == STALL || hazard) begin
            stall       = 1'b1;
            load_bubble = 1'b1;
        end
    end

    always_comb begin
        ctrl_d = CTRL_BUBBLE;
        da_d   = '0;
        db_d   = '0;
        imm_d  = '0;
        if (!load_bubble) begin
            ctrl_d = '{
                RegWrite: bus.RegWrite_ID,
                MemRead:  bus.MemRead_ID,
                MemWrite: bus.MemWrite_ID,
                setFlag:  bus.setFlag_ID,
                ALUOp:    bus.ALUOp_ID,
                Rd:       bus.Rd_ID
            };
            da_d   = bus.Da_ID;
            db_d   = bus.Db_ID;
            imm_d  = bus.imm_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_BUBBLE;
            da_q    <= '0;
            db_q    <= '0;
            imm_q   <= '0;
            bub_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            da_q   <= da_d;
            db_q   <= db_d;
            imm_q  <= imm_d;
            if (load_bubble && bub_q != '1) begin
                bub_q <= bub_q + CNT_W'(1);
            end
            unique case (state_q)
                RUN: begin
                    if (!bus.flush_ID && hazard) begin
                        cnt_q <= STALL_CYC;
                        if (LOAD_LAT > 1) state_q <= STALL;
                    end
                end
                STALL: begin
                    // cnt_q counts the STALL-state bubbles still owed, including this one.
                    if (bus.flush_ID || cnt_q == 2'd1) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.Rd_EX       = ctrl_q.Rd;
    assign bus.RegWrite_EX = ctrl_q.RegWrite;
    assign bus.MemRead_EX  = ctrl_q.MemRead;
    assign bus.MemWrite_EX = ctrl_q.MemWrite;
    assign bus.setFlag_EX  = ctrl_q.setFlag;
    assign bus.ALUOp_EX    = ctrl_q.ALUOp;
    assign bus.Da_EX       = da_q;
    assign bus.Db_EX       = db_q;
    assign bus.imm_EX      = imm_q;
    assign bus.stall_ID    = stall;
    assign bus.bubble_cnt  = bub_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: LOAD_LAT=1 and LOAD_LAT=3 instances against a behavioural model.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic        sf;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] imm;
    } ex_t;

    localparam ex_t BUB = {4'b0000, 3'b000, 5'd31, 192'd0};

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [4:0]  rd_id, rn_id, rm_id;
    logic        rw, mr, mw, sf, mov;
    logic [2:0]  op;
    logic [63:0] da, db, imm;
    logic        chk_en;

    int errors = 0;
    int checks = 0;

    ex_t             m_ex  [2];
    int              m_rem [2];
    longint unsigned m_cnt [2];
    int              lat   [2] = '{1, 3};
    longint unsigned cmax  [2] = '{64'hFFFF_FFFF, 64'd7};

    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(64), .CNT_W(32)) ifa ();
    id_ex_stage_reg_if #(.DATA_W(64), .CNT_W(3))  ifb ();

    assign ifa.flush_ID = flush;    assign ifb.flush_ID = flush;
    assign ifa.Rd_ID = rd_id;       assign ifb.Rd_ID = rd_id;
    assign ifa.Rn_ID = rn_id;       assign ifb.Rn_ID = rn_id;
    assign ifa.Rm_ID = rm_id;       assign ifb.Rm_ID = rm_id;
    assign ifa.RegWrite_ID = rw;    assign ifb.RegWrite_ID = rw;
    assign ifa.MemRead_ID = mr;     assign ifb.MemRead_ID = mr;
    assign ifa.MemWrite_ID = mw;    assign ifb.MemWrite_ID = mw;
    assign ifa.setFlag_ID = sf;     assign ifb.setFlag_ID = sf;
    assign ifa.isMOV_ID = mov;      assign ifb.isMOV_ID = mov;
    assign ifa.ALUOp_ID = op;       assign ifb.ALUOp_ID = op;
    assign ifa.Da_ID = da;          assign ifb.Da_ID = da;
    assign ifa.Db_ID = db;          assign ifb.Db_ID = db;
    assign ifa.imm_ID = imm;        assign ifb.imm_ID = imm;

    id_ex_stage_reg #(.DATA_W(64), .LOAD_LAT(1), .CNT_W(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    id_ex_stage_reg #(.DATA_W(64), .LOAD_LAT(3), .CNT_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a load in EX whose Rd the ID instruction reads forces LOAD_LAT bubbles.
    function automatic logic m_hazard(input int k);
        ex_t e = m_ex[k];
        return e.mr && e.rw && e.rd != 5'd31 &&
               (e.rd == rn_id || e.rd == rm_id || (mov && e.rd == rd_id));
    endfunction

    function automatic logic m_stall(input int k);
        return !flush && (m_rem[k] > 0 || m_hazard(k));
    endfunction

    function automatic longint unsigned m_inc(input int k);
        return (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ex[k]  <= BUB;
                m_rem[k] <= 0;
                m_cnt[k] <= 0;
            end else if (flush) begin
                m_ex[k]  <= BUB;
                m_rem[k] <= 0;
                m_cnt[k] <= m_inc(k);
            end else if (m_rem[k] > 0) begin
                m_ex[k]  <= BUB;
                m_rem[k] <= m_rem[k] - 1;
                m_cnt[k] <= m_inc(k);
            end else if (m_hazard(k)) begin
                m_ex[k]  <= BUB;
                m_rem[k] <= lat[k] - 1;
                m_cnt[k] <= m_inc(k);
            end else begin
                m_ex[k] <= {rw, mr, mw, sf, op, rd_id, da, db, imm};
            end
        end
    end

    ex_t             act_ex;
    logic            act_st;
    longint unsigned act_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    act_ex  = {ifa.RegWrite_EX, ifa.MemRead_EX, ifa.MemWrite_EX, ifa.setFlag_EX,
                               ifa.ALUOp_EX, ifa.Rd_EX, ifa.Da_EX, ifa.Db_EX, ifa.imm_EX};
                    act_st  = ifa.stall_ID;
                    act_cnt = 64'(ifa.bubble_cnt);
                end else begin
                    act_ex  = {ifb.RegWrite_EX, ifb.MemRead_EX, ifb.MemWrite_EX, ifb.setFlag_EX,
                               ifb.ALUOp_EX, ifb.Rd_EX, ifb.Da_EX, ifb.Db_EX, ifb.imm_EX};
                    act_st  = ifb.stall_ID;
                    act_cnt = 64'(ifb.bubble_cnt);
                end
                chk($sformatf("dut%0d ex_fields", k), act_ex, m_ex[k]);
                chk($sformatf("dut%0d bubble_cnt", k), act_cnt, m_cnt[k]);
                if (!reset) chk($sformatf("dut%0d stall_ID", k), act_st, m_stall(k));
            end
        end
    end

    task automatic drive(input logic [4:0] d, input logic [4:0] n, input logic [4:0] m,
                         input logic w, input logic r, input logic s, input logic f,
                         input logic mv, input logic [2:0] o, input logic [63:0] a);
        rd_id = d; rn_id = n; rm_id = m;
        rw = w; mr = r; mw = s; sf = f; mov = mv; op = o;
        da = a; db = ~a; imm = a + 64'h10;
    endtask

    task automatic nop();
        drive(5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; chk_en = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; chk_en = 1'b1;
        settle();
        chk("reset Rd_EX", ifa.Rd_EX, 31);
        chk("reset RegWrite_EX", ifa.RegWrite_EX, 0);
        chk("reset bubble_cnt", ifa.bubble_cnt, 0);
        chk("reset stall_ID", ifa.stall_ID, 0);

        // ADD X1,X2,X3
        drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 64'h1111);
        step(); nop(); settle();
        chk("add Rd_EX", ifa.Rd_EX, 1);
        chk("add RegWrite_EX", ifa.RegWrite_EX, 1);
        chk("add Da_EX", ifa.Da_EX, 64'h1111);
        chk("add stall_ID", ifa.stall_ID, 0);

        // LDUR X5 then ADD X6,X5,X7
        drive(5'd5, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 64'h2000);
        step();
        drive(5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 64'h3333);
        settle();
        chk("lu a stall", ifa.stall_ID, 1);
        chk("lu b stall1", ifb.stall_ID, 1);
        step(); settle();
        chk("lu a bubble RegWrite", ifa.RegWrite_EX, 0);
        chk("lu a bubble Rd", ifa.Rd_EX, 31);
        chk("lu a stall released", ifa.stall_ID, 0);
        chk("lu a bubble_cnt", ifa.bubble_cnt, 1);
        chk("lu b stall2", ifb.stall_ID, 1);
        step(); settle();
        chk("lu a add in EX", ifa.Rd_EX, 6);
        chk("lu b stall3", ifb.stall_ID, 1);
        step(); settle();
        chk("lu b stall end", ifb.stall_ID, 0);
        chk("lu b bubble_cnt", ifb.bubble_cnt, 3);
        step(); settle();
        chk("lu b add in EX", ifb.Rd_EX, 6);
        nop();

        // LDUR X31 never stalls; LDUR X5 then MOVK X5 does
        drive(5'd31, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 64'h4000);
        step();
        drive(5'd6, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 64'h5555);
        settle();
        chk("x31 a no stall", ifa.stall_ID, 0);
        chk("x31 b no stall", ifb.stall_ID, 0);
        step();
        drive(5'd5, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 64'h6000);
        step();
        drive(5'd5, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 64'h7777);
        settle();
        chk("movk a stall", ifa.stall_ID, 1);
        step(); nop();
        repeat (3) step();

        // Hazard and flush together
        drive(5'd5, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 64'h8000);
        step();
        drive(5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 64'h9999);
        flush = 1'b1;
        settle();
        chk("flush a stall", ifa.stall_ID, 0);
        chk("flush b stall", ifb.stall_ID, 0);
        step(); flush = 1'b0; nop(); settle();
        chk("flush a Rd", ifa.Rd_EX, 31);
        chk("flush a RegWrite", ifa.RegWrite_EX, 0);
        chk("flush a bubble_cnt", ifa.bubble_cnt, 3);

        // Flush in the second stall cycle of the LOAD_LAT=3 instance
        drive(5'd5, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 64'hA000);
        step();
        drive(5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 64'hBBBB);
        settle();
        chk("sflush b stall1", ifb.stall_ID, 1);
        step(); flush = 1'b1; settle();
        chk("sflush b stall aborted", ifb.stall_ID, 0);
        step(); flush = 1'b0; settle();
        chk("sflush b run", ifb.stall_ID, 0);
        chk("sflush b Rd", ifb.Rd_EX, 31);
        step(); nop();

        // Reset in the middle of a stall
        drive(5'd5, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 64'hC000);
        step();
        drive(5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 64'hDDDD);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; nop(); settle();
        chk("rst b Rd", ifb.Rd_EX, 31);
        chk("rst b RegWrite", ifb.RegWrite_EX, 0);
        chk("rst b MemRead", ifb.MemRead_EX, 0);
        chk("rst b bubble_cnt", ifb.bubble_cnt, 0);
        chk("rst b stall", ifb.stall_ID, 0);

        // Saturation: 9 flush bubbles into a 3-bit counter
        flush = 1'b1;
        repeat (9) step();
        settle();
        chk("sat b bubble_cnt", ifb.bubble_cnt, 7);
        chk("sat a bubble_cnt", ifa.bubble_cnt, 9);
        flush = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
